// File: rtl/eq_pkg.sv
// Shared equalizer types, widths and the saturating output scaler.
// Imported by the band scheduler, its MAC and the band-gain mixer.
package eq_pkg;

  localparam int DW = 24;
  localparam int CW = 12;
  localparam int CFRAC = 11;
  localparam int N_TAPS_DEF = 31;
  localparam int N_BANDS_DEF = 3;
  localparam int PW = DW + CW;
  localparam int AW = PW + $clog2(N_TAPS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    EMIT
  } fsm_state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sat;
  } sat_res_t;

  localparam logic signed [AW-1:0] SMAX =
    AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  // Floor-shift out the coefficient fraction, then clip to DW.
  function automatic sat_res_t sat_shift(
    input logic signed [AW-1:0] a
  );
    logic signed [AW-1:0] r;
    sat_res_t o;
    r = a >>> CFRAC;
    o.sat = 1'b1;
    if (r > SMAX) begin
      o.data = SMAX[DW-1:0];
    end else if (r < SMIN) begin
      o.data = SMIN[DW-1:0];
    end else begin
      o.data = r[DW-1:0];
      o.sat = 1'b0;
    end
    return o;
  endfunction

endpackage

// File: rtl/eq_mac_unit.sv
// Shared multiply-accumulate: sample register, accumulator,
// and a result register holding the scaled, saturated band sum.
module eq_mac_unit
  import eq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          smp_ld,
  input  logic [DW-1:0] smp_in,
  input  logic [CW-1:0] coef_data,
  input  logic          acc_clr,
  input  logic          res_ld,
  output logic [DW-1:0] res_data,
  output logic          res_sat
);

  logic [DW-1:0] smp_q;
  logic rd_d;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [PW-1:0] prod;
  sat_res_t res;

  assign prod =
    $signed({{CW{smp_q[DW-1]}}, smp_q}) *
    $signed({{DW{coef_data[CW-1]}}, coef_data});

  assign acc_nxt = rd_d
    ? acc + {{(AW-PW){prod[PW-1]}}, prod}
    : acc;

  assign res = sat_shift(acc_nxt);

  // rd_d follows the read strobe even when frozen, so a read
  // issued just before a stall still lands in the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      rd_d <= 1'b0;
      acc <= '0;
      res_data <= '0;
      res_sat <= 1'b0;
    end else begin
      rd_d <= smp_ld;
      if (smp_ld) smp_q <= smp_in;
      if (acc_clr) acc <= '0;
      else acc <= acc_nxt;
      if (res_ld) begin
        res_data <= res.data;
        res_sat <= res.sat;
      end
    end
  end

endmodule

// File: rtl/fir_band_scheduler.sv
// Runs every equalizer band FIR through one shared MAC: history
// buffer, coefficient address sequencing and band-ordered results.
module fir_band_scheduler
  import eq_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int N_BANDS = N_BANDS_DEF,
  localparam int AAW = $clog2(N_BANDS * N_TAPS),
  localparam int BW = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [DW-1:0]  in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [AAW-1:0] coef_addr,
  output logic           coef_rd,
  input  logic [CW-1:0]  coef_data,
  output logic [DW-1:0]  out_data,
  output logic [BW-1:0]  out_band,
  output logic           out_sat,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int TW = $clog2(N_TAPS);
  localparam logic [TW-1:0] TLAST = TW'(N_TAPS - 1);
  localparam logic [BW-1:0] BLAST = BW'(N_BANDS - 1);

  fsm_state_t state;
  logic [TW-1:0] wr_ptr;
  logic [TW-1:0] base;
  logic [TW-1:0] tap;
  logic [TW-1:0] rd_idx;
  logic [BW-1:0] band;
  logic [DW-1:0] hist [N_TAPS];
  logic run_c;

  assign run_c = enable && (state == RUN);
  assign in_ready = enable && (state == IDLE);
  assign coef_rd = run_c;
  assign coef_addr =
    AAW'(int'(band) * N_TAPS + int'(tap));

  // Tap t looks t samples back from the newest one.
  assign rd_idx = (base >= tap)
    ? base - tap
    : base + TW'(N_TAPS) - tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      base <= '0;
      band <= '0;
      tap <= '0;
      out_valid <= 1'b0;
      out_band <= '0;
      for (int i = 0; i < N_TAPS; i++) hist[i] <= '0;
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            hist[wr_ptr] <= in_data;
            base <= wr_ptr;
            band <= '0;
            tap <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (tap == TLAST) state <= FLUSH;
          else tap <= tap + TW'(1);
        end
        FLUSH: begin
          state <= EMIT;
          out_valid <= 1'b1;
          out_band <= band;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (band != BLAST) begin
              band <= band + BW'(1);
              tap <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
              wr_ptr <= (wr_ptr == TLAST)
                ? '0 : wr_ptr + TW'(1);
            end
          end
        end
      endcase
    end
  end

  eq_mac_unit u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp_ld    (coef_rd),
    .smp_in    (hist[rd_idx]),
    .coef_data (coef_data),
    .acc_clr   (run_c && (tap == '0)),
    .res_ld    (enable && (state == FLUSH)),
    .res_data  (out_data),
    .res_sat   (out_sat)
  );

endmodule

// File: tb/tb_fir_band_scheduler.sv
// Bench for fir_band_scheduler: gain table, hand-built corner
// sequences and a random run scored against a sum-of-products model.
module tb_fir_band_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic [23:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [6:0] coef_addr;
  logic coef_rd;
  logic [11:0] coef_data;
  logic [23:0] out_data;
  logic [1:0] out_band;
  logic out_sat;
  logic out_valid;
  logic out_ready;

  fir_band_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_addr (coef_addr),
    .coef_rd   (coef_rd),
    .coef_data (coef_data),
    .out_data  (out_data),
    .out_band  (out_band),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     band;
    longint data;
    bit     sat;
  } res_t;

  typedef struct {
    logic signed [23:0] x;
    logic signed [11:0] c;
    longint             e;
    bit                 s;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit have_acc = 0;
  int lat = 0;
  logic ov_q = 1'b0;
  logic signed [11:0] cmem [93];
  longint sq[$];
  res_t expq[$];
  int gapq[$];
  longint last_d [3];
  bit last_s [3];

  function automatic void chk(
    input string nm, input longint act, input longint exp
  );
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void fail_to(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endfunction

  // Direct convolution over every sample accepted since reset.
  function automatic res_t model(input int b);
    longint s = 0;
    longint r;
    res_t o;
    for (int t = 0; t < 31; t++) begin
      int i = sq.size() - 1 - t;
      if (i >= 0) s += sq[i] * longint'(cmem[b*31 + t]);
    end
    r = s >>> 11;
    o.band = b;
    o.sat = 0;
    if (r > 8388607) begin
      r = 8388607;
      o.sat = 1;
    end else if (r < -8388608) begin
      r = -8388608;
      o.sat = 1;
    end
    o.data = r;
    return o;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    coef_data <= coef_rd ? cmem[coef_addr] : 12'($urandom);

  always @(negedge clk) begin
    res_t e;
    ov_q <= out_valid;
    if (!rst_n) begin
      sq.delete();
      expq.delete();
    end else begin
      if (in_valid && in_ready) begin
        sq.push_back(longint'($signed(in_data)));
        for (int b = 0; b < 3; b++) expq.push_back(model(b));
        if (have_acc) gapq.push_back(cyc - acc_cyc);
        acc_cyc <= cyc;
        have_acc <= 1;
      end
      if (out_valid && !ov_q && out_band == 2'd0)
        lat <= cyc - acc_cyc;
      if (out_valid && out_ready && enable) begin
        if (expq.size() == 0) begin
          fail_to("out_unexpected");
        end else begin
          e = expq.pop_front();
          chk("out_band", longint'(out_band), e.band);
          chk("out_data", $signed(out_data), e.data);
          chk("out_sat", longint'(out_sat), e.sat);
          last_d[e.band] = $signed(out_data);
          last_s[e.band] = out_sat;
        end
      end
    end
  end

  task automatic send(input logic [23:0] x);
    int w = 0;
    @(posedge clk);
    #1;
    in_data = x;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 2000) begin
        fail_to("send");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (expq.size() != 0) begin
      @(negedge clk);
      w++;
      if (w > 3000) begin
        fail_to("drain");
        expq.delete();
        break;
      end
    end
    #1;
  endtask

  task automatic run(input logic [23:0] x);
    send(x);
    drain();
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_coef_rd", longint'(coef_rd), 0);
    chk("rst_coef_addr", longint'(coef_addr), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_band", longint'(out_band), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
  endtask

  task automatic cmem_fill(input int v, input bit rnd);
    for (int i = 0; i < 93; i++)
      cmem[i] = rnd ? 12'($urandom) : 12'(v);
  endtask

  initial begin
    vec_t tv [9];
    int w;
    int pend;
    int guard;
    bit took;

    tv[0] = '{24'sd1000, 12'sd1024, 500, 0};
    tv[1] = '{-24'sd1000, 12'sd1024, -500, 0};
    tv[2] = '{-24'sd1, 12'sd1, -1, 0};
    tv[3] = '{24'sd1, 12'sd1, 0, 0};
    tv[4] = '{24'h7fffff, 12'sd2047, 8384511, 0};
    tv[5] = '{24'h800000, 12'h800, 8388607, 1};
    tv[6] = '{24'h800000, 12'sd2047, -8384512, 0};
    tv[7] = '{24'h7fffff, 12'h800, -8388607, 0};
    tv[8] = '{24'sd5000, -12'sd1, -3, 0};

    rst_n = 1'b0;
    enable = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    cmem_fill(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cmem_fill(0, 0);
      cmem[0] = tv[i].c;
      run(tv[i].x);
      chk("gain_b0", last_d[0], tv[i].e);
      chk("gain_sat", longint'(last_s[0]), tv[i].s);
      chk("gain_b1", last_d[1], 0);
      chk("gain_b2", last_d[2], 0);
      if (i == 0) chk("latency", lat, 33);
    end

    cmem_fill(0, 1);
    out_ready = 1'b0;
    send(24'($urandom));
    @(negedge clk);
    chk("first_rd", longint'(coef_rd), 1);
    chk("first_addr", longint'(coef_addr), 0);
    chk("busy_ready", longint'(in_ready), 0);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) fail_to("bp_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_data", $signed(out_data), expq[0].data);
      chk("bp_sat", longint'(out_sat), expq[0].sat);
      chk("bp_band", longint'(out_band), 0);
      chk("bp_rd", longint'(coef_rd), 0);
      chk("bp_ready", longint'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("resume_rd", longint'(coef_rd), 1);
    chk("resume_addr", longint'(coef_addr), 31);
    drain();

    send(24'($urandom));
    w = 0;
    while (expq.size() > 2 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    chk("mid_b1_run",
        longint'(coef_rd && coef_addr >= 31 && coef_addr < 62), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cmem_fill(0, 0);
    for (int t = 0; t < 31; t++) cmem[31 + t] = 12'(t + 1);
    for (int k = 0; k < 32; k++) begin
      run(k == 0 ? 24'd2048 : 24'd0);
      chk("impulse_b1", last_d[1], k < 31 ? k + 1 : 0);
    end

    cmem_fill(2047, 0);
    repeat (31) run(24'h7fffff);
    chk("sat_pos", last_d[0], 8388607);
    chk("sat_pos_flag", longint'(last_s[0]), 1);
    repeat (31) run(24'h800000);
    chk("sat_neg", last_d[0], -8388608);
    chk("sat_neg_flag", longint'(last_s[0]), 1);

    cmem_fill(0, 1);
    send(24'($urandom));
    gapq.delete();
    repeat (5) send(24'($urandom));
    if (gapq.size() != 5) fail_to("gap_count");
    else for (int i = 0; i < 5; i++) chk("gap", gapq[i], 100);
    drain();

    send(24'($urandom));
    gapq.delete();
    repeat (10) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("frozen_rd", longint'(coef_rd), 0);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    send(24'($urandom));
    if (gapq.size() != 1) fail_to("en_gap");
    else chk("en_gap", gapq[0], 104);
    drain();

    cmem_fill(0, 1);
    pend = 20;
    guard = 0;
    took = 0;
    while ((pend > 0 || in_valid || expq.size() > 0)
           && guard < 20000) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      if (took) begin
        in_valid = 1'b0;
        took = 0;
      end
      if (!in_valid && pend > 0 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data = 24'($urandom);
        pend--;
      end
      @(negedge clk);
      if (in_valid && in_ready) took = 1;
      guard++;
    end
    if (guard >= 20000) fail_to("random_run");
    enable = 1'b1;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
